fpu_config_regs: RTL and testbench
==================================

FPU_CONFIG_REGS -- requirements
Module: fpu_config_regs

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
  M_DIMS_ADDRESS  32'h1000_0000  image dims word {width[31:16], height[15:0]}
  M_START_ADDRESS  32'h1000_0020  image start address
  M_FILTER_ADDRESS  32'h1000_0040  filter words at +0, +4, +8
  M_RESULT_ADDRESS  32'h1000_0100  result address
  M_STARTSIG_ADDRESS  32'h1000_0120  start/status word
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
  clk  in  1  single clock, all state on rising edge
  rst  in  1  asynchronous, active-high reset
  cpu_wr_en  in  1  CPU write strobe
  cpu_rd_en  in  1  CPU read strobe
  cpu_addr  in  32  CPU word address
  cpu_wdata  in  32  CPU write data
  cpu_rdata  out  32  CPU read data
  cpu_rdata_valid  out  1  CPU read data valid
  cpu_wr_err  out  1  one-cycle pulse, write rejected
  address_mem  in  32  FPU-side read address
  data_mem  out  32  FPU-side read data
  mapped_data_valid  out  1  FPU-side read data valid
  load_config_start  out  1  one-cycle pulse, starts FPU config load
  load_config_done  in  1  FPU config load complete
  busy  out  1  high from start pulse until done

Function
REQ-003 SHALL hold seven 32-bit registers: DIMS, START, FILTER0, FILTER1, FILTER2, RESULT, plus STATUS at M_STARTSIG_ADDRESS.
REQ-004 SHALL store CPU write data raw (no byte swap). FILTER2 SHALL store the full word; only bits [31:24] are consumed downstream.
REQ-005 FPU read SHALL have 1-cycle latency: address_mem matching a mapped register at cycle N → data_mem = value, mapped_data_valid = 1 in cycle N+1. This SHALL repeat every cycle the address is held.
REQ-006 An unmapped address_mem SHALL give data_mem = 0 and mapped_data_valid = 0 in the next cycle.
REQ-007 CPU read SHALL have 1-cycle latency: cpu_rd_en with a mapped address → cpu_rdata and cpu_rdata_valid = 1 next cycle. Unmapped → cpu_rdata = 0, cpu_rdata_valid = 1.
REQ-008 A read of STATUS SHALL return {30'b0, done_sticky, busy}.
REQ-009 The FSM SHALL have states IDLE, START, LOADING:
  IDLE→START on a CPU write to STARTSIG with wdata[0] = 1.
  START→LOADING unconditionally after 1 cycle.
  LOADING→IDLE when load_config_done = 1.
REQ-010 load_config_start SHALL be 1 only in START (exactly one cycle). busy SHALL be 1 in START and LOADING.
REQ-011 done_sticky SHALL set on LOADING→IDLE and clear on the IDLE→START transition.
REQ-012 CPU writes to any register while busy = 1 SHALL be dropped and SHALL pulse cpu_wr_err for one cycle, starting the cycle after the write.
REQ-013 A STARTSIG write with wdata[0] = 0 in IDLE SHALL have no effect and SHALL NOT raise an error.
REQ-014 On a same-cycle CPU write and FPU or CPU read of the same register, the read SHALL return the pre-write value.
REQ-015 cpu_wr_en and cpu_rd_en asserted together SHALL both be serviced.
REQ-016 load_config_done while not in LOADING SHALL be ignored.
REQ-017 All addresses SHALL be compared on the full 32 bits; misaligned addresses are unmapped.

Reset
REQ-018 While rst = 1, asynchronously: all registers 0, done_sticky 0, FSM IDLE, and every output 0.
REQ-019 rst asserted mid-LOADING SHALL abort to IDLE. A later load_config_done SHALL be ignored.

Verification
REQ-020 Write DIMS = 0x0280_01E0, START = 0x2000_0000, FILTER0..2 = 0x01020304 / 0x05060708 / 0x09000000, RESULT = 0x3000_0000. FPU reads each address → matching data_mem with mapped_data_valid one cycle later.
REQ-021 Write STARTSIG = 1 → load_config_start high exactly one cycle, busy = 1. Drive load_config_done two cycles later → busy = 0; STATUS read = 0x2.
REQ-022 Write DIMS = 0xFFFF_FFFF while busy → cpu_wr_err pulses; DIMS unchanged; after done, DIMS read returns the old value.
REQ-023 FPU reads address 0x1000_0004 → data_mem = 0, mapped_data_valid = 0. CPU reads the same address → cpu_rdata = 0, cpu_rdata_valid = 1.
REQ-024 Same-cycle CPU write START = 0xAAAA_0000 and FPU read of START (old 0x2000_0000) → 0x2000_0000 returned; next read → 0xAAAA_0000.
REQ-025 Assert rst during LOADING → all outputs 0 immediately. A following load_config_done is ignored. A new start works normally.

Source files
------------

// File: rtl/fpu_config_regs_if.sv
// CPU/FPU access bus for the FPU configuration register block.
// The design drives the slave-side outputs; a CPU/FPU model drives the master side.
interface fpu_config_regs_if;
  logic        cpu_wr_en;
  logic        cpu_rd_en;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_rdata_valid;
  logic        cpu_wr_err;
  logic [31:0] address_mem;
  logic [31:0] data_mem;
  logic        mapped_data_valid;
  logic        load_config_start;
  logic        load_config_done;
  logic        busy;

  modport master (
    output cpu_wr_en, cpu_rd_en, cpu_addr, cpu_wdata, address_mem, load_config_done,
    input  cpu_rdata, cpu_rdata_valid, cpu_wr_err, data_mem, mapped_data_valid,
           load_config_start, busy
  );

  modport slave (
    input  cpu_wr_en, cpu_rd_en, cpu_addr, cpu_wdata, address_mem, load_config_done,
    output cpu_rdata, cpu_rdata_valid, cpu_wr_err, data_mem, mapped_data_valid,
           load_config_start, busy
  );
endinterface

// File: rtl/fpu_config_regs.sv
// CPU-programmed FPU configuration registers with a FPU-side read port and a
// start/busy/done handshake that kicks off the FPU configuration load.
module fpu_config_regs #(
  parameter logic [31:0] M_DIMS_ADDRESS     = 32'h1000_0000,
  parameter logic [31:0] M_START_ADDRESS    = 32'h1000_0020,
  parameter logic [31:0] M_FILTER_ADDRESS   = 32'h1000_0040,
  parameter logic [31:0] M_RESULT_ADDRESS   = 32'h1000_0100,
  parameter logic [31:0] M_STARTSIG_ADDRESS = 32'h1000_0120
) (
  input  logic               clk,
  input  logic               rst,
  fpu_config_regs_if.slave   bus
);

  localparam int unsigned DW = 32;
  localparam logic [31:0] FILTER0_ADDR = M_FILTER_ADDRESS;
  localparam logic [31:0] FILTER1_ADDR = M_FILTER_ADDRESS + 32'd4;
  localparam logic [31:0] FILTER2_ADDR = M_FILTER_ADDRESS + 32'd8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_LOADING = 2'd2
  } state_e;

  state_e        state_q;
  logic [DW-1:0] dims_q, start_q, filter0_q, filter1_q, filter2_q, result_q;
  logic          done_sticky_q;
  logic          busy_q;
  logic          load_start_q;
  logic          wr_err_q;
  logic [DW-1:0] data_mem_q;
  logic          mapped_valid_q;
  logic [DW-1:0] cpu_rdata_q;
  logic          cpu_rdata_valid_q;

  logic [DW-1:0] status_w;
  logic          fpu_hit_d, cpu_hit_d;
  logic [DW-1:0] fpu_val_d, cpu_val_d;
  logic          wr_accept_d;
  logic          start_req_d;

  assign status_w = {30'b0, done_sticky_q, busy_q};

  // Full 32-bit address decode; anything else, including misaligned, is unmapped.
  function automatic logic [DW:0] rd_mux(input logic [31:0] a,
                                         input logic [DW-1:0] dims, strt, f0, f1, f2,
                                         input logic [DW-1:0] res, stat);
    logic [DW:0] r;
    r = '0;
    if      (a == M_DIMS_ADDRESS)     r = {1'b1, dims};
    else if (a == M_START_ADDRESS)    r = {1'b1, strt};
    else if (a == FILTER0_ADDR)       r = {1'b1, f0};
    else if (a == FILTER1_ADDR)       r = {1'b1, f1};
    else if (a == FILTER2_ADDR)       r = {1'b1, f2};
    else if (a == M_RESULT_ADDRESS)   r = {1'b1, res};
    else if (a == M_STARTSIG_ADDRESS) r = {1'b1, stat};
    return r;
  endfunction

  always_comb begin
    {fpu_hit_d, fpu_val_d} = rd_mux(bus.address_mem, dims_q, start_q, filter0_q,
                                    filter1_q, filter2_q, result_q, status_w);
    {cpu_hit_d, cpu_val_d} = rd_mux(bus.cpu_addr, dims_q, start_q, filter0_q,
                                    filter1_q, filter2_q, result_q, status_w);
    wr_accept_d = bus.cpu_wr_en & ~busy_q;
    start_req_d = wr_accept_d & (bus.cpu_addr == M_STARTSIG_ADDRESS) & bus.cpu_wdata[0];
  end

  // Reads sample pre-write register values, so a same-cycle write is seen one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      dims_q            <= '0;
      start_q           <= '0;
      filter0_q         <= '0;
      filter1_q         <= '0;
      filter2_q         <= '0;
      result_q          <= '0;
      done_sticky_q     <= 1'b0;
      busy_q            <= 1'b0;
      load_start_q      <= 1'b0;
      wr_err_q          <= 1'b0;
      data_mem_q        <= '0;
      mapped_valid_q    <= 1'b0;
      cpu_rdata_q       <= '0;
      cpu_rdata_valid_q <= 1'b0;
    end else begin
      data_mem_q        <= fpu_hit_d ? fpu_val_d : '0;
      mapped_valid_q    <= fpu_hit_d;
      cpu_rdata_q       <= (bus.cpu_rd_en && cpu_hit_d) ? cpu_val_d : '0;
      cpu_rdata_valid_q <= bus.cpu_rd_en;
      wr_err_q          <= bus.cpu_wr_en & busy_q;

      if (wr_accept_d) begin
        if      (bus.cpu_addr == M_DIMS_ADDRESS)   dims_q    <= bus.cpu_wdata;
        else if (bus.cpu_addr == M_START_ADDRESS)  start_q   <= bus.cpu_wdata;
        else if (bus.cpu_addr == FILTER0_ADDR)     filter0_q <= bus.cpu_wdata;
        else if (bus.cpu_addr == FILTER1_ADDR)     filter1_q <= bus.cpu_wdata;
        else if (bus.cpu_addr == FILTER2_ADDR)     filter2_q <= bus.cpu_wdata;
        else if (bus.cpu_addr == M_RESULT_ADDRESS) result_q  <= bus.cpu_wdata;
      end

      // Load handshake: one-cycle start pulse, busy until the FPU reports done.
      case (state_q)
        S_IDLE: begin
          if (start_req_d) begin
            state_q       <= S_START;
            load_start_q  <= 1'b1;
            busy_q        <= 1'b1;
            done_sticky_q <= 1'b0;
          end
        end
        S_START: begin
          state_q      <= S_LOADING;
          load_start_q <= 1'b0;
        end
        S_LOADING: begin
          if (bus.load_config_done) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            done_sticky_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          load_start_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_rdata         = cpu_rdata_q;
  assign bus.cpu_rdata_valid   = cpu_rdata_valid_q;
  assign bus.cpu_wr_err        = wr_err_q;
  assign bus.data_mem          = data_mem_q;
  assign bus.mapped_data_valid = mapped_valid_q;
  assign bus.load_config_start = load_start_q;
  assign bus.busy              = busy_q;

endmodule

// File: tb/tb_fpu_config_regs.sv
// Scoreboard bench for fpu_config_regs: expected read results are queued as
// reads are driven and compared when the registered outputs appear.
module tb_fpu_config_regs;

  localparam logic [31:0] A_DIMS  = 32'h1000_0000;
  localparam logic [31:0] A_START = 32'h1000_0020;
  localparam logic [31:0] A_F0    = 32'h1000_0040;
  localparam logic [31:0] A_F1    = 32'h1000_0044;
  localparam logic [31:0] A_F2    = 32'h1000_0048;
  localparam logic [31:0] A_RES   = 32'h1000_0100;
  localparam logic [31:0] A_SIG   = 32'h1000_0120;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        valid;
  } exp_t;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  exp_t cpu_q[$];
  exp_t fpu_q[$];

  fpu_config_regs_if bus ();

  fpu_config_regs dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (cpu_q.size() > 0) begin
      e = cpu_q.pop_front();
      check_eq({e.tag, "_cpu"}, {bus.cpu_rdata_valid, bus.cpu_rdata}, {e.valid, e.data});
    end
    if (fpu_q.size() > 0) begin
      e = fpu_q.pop_front();
      check_eq({e.tag, "_fpu"}, {bus.mapped_data_valid, bus.data_mem}, {e.valid, e.data});
    end
  end

  // One bus cycle, started just after a falling edge; returns at the next falling edge.
  task automatic bus_cycle(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic done,
                           input logic fchk, input logic [31:0] faddr,
                           input string tag, input logic [31:0] cexp,
                           input logic [31:0] fexp, input logic fexp_v);
    exp_t e;
    bus.cpu_wr_en        = wr;
    bus.cpu_rd_en        = rd;
    bus.cpu_addr         = addr;
    bus.cpu_wdata        = wdata;
    bus.load_config_done = done;
    if (fchk) bus.address_mem = faddr;
    if (rd) begin
      e.tag = tag; e.data = cexp; e.valid = 1'b1;
      cpu_q.push_back(e);
    end
    if (fchk) begin
      e.tag = tag; e.data = fexp; e.valid = fexp_v;
      fpu_q.push_back(e);
    end
    @(negedge clk);
    bus.cpu_wr_en        = 1'b0;
    bus.cpu_rd_en        = 1'b0;
    bus.load_config_done = 1'b0;
  endtask

  task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
    bus_cycle(1'b1, 1'b0, a, d, 1'b0, 1'b0, 32'h0, "wr", 32'h0, 32'h0, 1'b0);
  endtask

  task automatic cpu_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus_cycle(1'b0, 1'b1, a, 32'h0, 1'b0, 1'b0, 32'h0, tag, exp, 32'h0, 1'b0);
  endtask

  task automatic fpu_rd(input string tag, input logic [31:0] a, input logic [31:0] exp,
                        input logic exp_v);
    bus_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, a, tag, 32'h0, exp, exp_v);
  endtask

  task automatic idle(input logic done);
    bus_cycle(1'b0, 1'b0, 32'h0, 32'h0, done, 1'b0, 32'h0, "idle", 32'h0, 32'h0, 1'b0);
  endtask

  task automatic check_outs_zero(input string tag);
    check_eq({tag, "_rdata"}, 33'(bus.cpu_rdata), 33'd0);
    check_eq({tag, "_flags"}, 33'({bus.cpu_rdata_valid, bus.cpu_wr_err, bus.mapped_data_valid,
                                   bus.load_config_start, bus.busy}), 33'd0);
    check_eq({tag, "_data_mem"}, 33'(bus.data_mem), 33'd0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    bus.cpu_wr_en = 1'b0; bus.cpu_rd_en = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.address_mem = '0; bus.load_config_done = 1'b0;
    #12;
    check_outs_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Program all configuration registers and read them back on the FPU port.
    cpu_wr(A_DIMS,  32'h0280_01E0);
    cpu_wr(A_START, 32'h2000_0000);
    cpu_wr(A_F0,    32'h0102_0304);
    cpu_wr(A_F1,    32'h0506_0708);
    cpu_wr(A_F2,    32'h0900_0000);
    cpu_wr(A_RES,   32'h3000_0000);
    fpu_rd("dims",  A_DIMS,  32'h0280_01E0, 1'b1);
    fpu_rd("dims2", A_DIMS,  32'h0280_01E0, 1'b1);
    fpu_rd("start", A_START, 32'h2000_0000, 1'b1);
    fpu_rd("f0",    A_F0,    32'h0102_0304, 1'b1);
    fpu_rd("f1",    A_F1,    32'h0506_0708, 1'b1);
    fpu_rd("f2",    A_F2,    32'h0900_0000, 1'b1);
    fpu_rd("res",   A_RES,   32'h3000_0000, 1'b1);
    fpu_rd("stat0", A_SIG,   32'h0,         1'b1);
    cpu_rd("cdims", A_DIMS,  32'h0280_01E0);
    cpu_rd("cf2",   A_F2,    32'h0900_0000);

    // Unmapped and misaligned addresses.
    fpu_rd("unmap",  32'h1000_0004, 32'h0, 1'b0);
    fpu_rd("misal",  32'h1000_0001, 32'h0, 1'b0);
    cpu_rd("cunmap", 32'h1000_0004, 32'h0);
    cpu_rd("chigh",  32'h2000_0000, 32'h0);

    // Start handshake with a rejected write while busy.
    cpu_wr(A_SIG, 32'h1);
    check_eq("start_pulse", 33'(bus.load_config_start), 33'd1);
    check_eq("busy_start",  33'(bus.busy), 33'd1);
    fpu_rd("stat_busy", A_SIG, 32'h1, 1'b1);
    check_eq("start_gone", 33'(bus.load_config_start), 33'd0);
    check_eq("busy_load",  33'(bus.busy), 33'd1);
    cpu_wr(A_DIMS, 32'hFFFF_FFFF);
    check_eq("wr_err", 33'(bus.cpu_wr_err), 33'd1);
    idle(1'b1);
    check_eq("wr_err_end", 33'(bus.cpu_wr_err), 33'd0);
    check_eq("busy_done",  33'(bus.busy), 33'd0);
    cpu_rd("stat_done", A_SIG, 32'h2);
    cpu_rd("dims_kept", A_DIMS, 32'h0280_01E0);

    // STARTSIG with bit0 clear and a stray done are both no-ops in IDLE.
    cpu_wr(A_SIG, 32'hFFFF_FFFE);
    check_eq("nostart_err", 33'({bus.cpu_wr_err, bus.busy, bus.load_config_start}), 33'd0);
    idle(1'b1);
    cpu_rd("stat_keep", A_SIG, 32'h2);

    // Same-cycle write and read return the pre-write value.
    bus_cycle(1'b1, 1'b0, A_START, 32'hAAAA_0000, 1'b0, 1'b1, A_START,
              "rw_fpu", 32'h0, 32'h2000_0000, 1'b1);
    fpu_rd("rw_fpu_new", A_START, 32'hAAAA_0000, 1'b1);
    bus_cycle(1'b1, 1'b1, A_RES, 32'h0000_0055, 1'b0, 1'b0, 32'h0,
              "rw_cpu", 32'h3000_0000, 32'h0, 1'b0);
    cpu_rd("rw_cpu_new", A_RES, 32'h0000_0055);

    // Reset during LOADING aborts; a late done is ignored; a new start works.
    fpu_rd("pre_rst", A_DIMS, 32'h0280_01E0, 1'b1);
    cpu_wr(A_SIG, 32'h1);
    idle(1'b0);
    check_eq("loading_busy", 33'(bus.busy), 33'd1);
    #2 rst = 1'b1;
    #1 check_outs_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    idle(1'b1);
    check_eq("late_done", 33'({bus.busy, bus.load_config_start}), 33'd0);
    cpu_rd("stat_rst", A_SIG, 32'h0);
    cpu_rd("dims_rst", A_DIMS, 32'h0);
    cpu_wr(A_SIG, 32'h1);
    check_eq("restart_pulse", 33'({bus.load_config_start, bus.busy}), 33'b11);
    idle(1'b0);
    idle(1'b1);
    check_eq("restart_idle", 33'(bus.busy), 33'd0);
    cpu_rd("stat_restart", A_SIG, 32'h2);
    idle(1'b0);

    if (cpu_q.size() != 0 || fpu_q.size() != 0) begin
      n_total++;
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d exp=0", cpu_q.size() + fpu_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
